// File: rtl/dc_fifo_pkg.sv
// Shared helpers for the dual-clock FIFO halves.
// Pointer codecs work on a wide word; callers slice to their width.
package dc_fifo_pkg;

  localparam int unsigned PW_MAX = 32;

  typedef logic [PW_MAX-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = g;
    for (int i = 1; i < PW_MAX; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/dc_sync_bus.sv
// Multi-flop synchronizer for a Gray-coded bus.
// Kept standalone so CDC constraints can target it.
module dc_sync_bus #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/dc_event_reader.sv
// Read side of a dual-clock event FIFO: syncs the remote
// Gray write token and drains slots into a registered output.
module dc_event_reader
  import dc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int BUFFER_DEPTH = 8,
  parameter int SYNC_STAGES  = 2,
  localparam int AW = $clog2(BUFFER_DEPTH),
  localparam int PW = AW + 1
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic [BUFFER_DEPTH*DATA_WIDTH-1:0] data_async_i,
  input  logic [PW-1:0]                  writetoken_i,
  output logic [PW-1:0]                  readpointer_o,
  output logic [DATA_WIDTH-1:0]          data_o,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [PW-1:0]                  fill_o
);

  logic [PW-1:0]         wgray_s;
  logic [PW-1:0]         wbin_d, wbin_q;
  logic [PW-1:0]         rbin_d, rbin_q;
  logic [PW-1:0]         rptr_d, rptr_q;
  logic [DATA_WIDTH-1:0] data_d, data_q;
  logic                  valid_d, valid_q;
  logic                  empty, load;
  ptr_t                  wconv, rconv;

  logic [DATA_WIDTH-1:0] slot [BUFFER_DEPTH];

  for (genvar k = 0; k < BUFFER_DEPTH; k++) begin : g_slot
    assign slot[k] = data_async_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  dc_sync_bus #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (writetoken_i),
    .q_o    (wgray_s)
  );

  assign wconv  = gray2bin(ptr_t'(wgray_s));
  assign wbin_d = wconv[PW-1:0];

  assign empty = (wbin_q == rbin_q);
  assign load  = !empty && (!valid_q || ready_i);

  always_comb begin
    rbin_d  = rbin_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = slot[rbin_q[AW-1:0]];
      valid_d = 1'b1;
      rbin_d  = rbin_q + {{AW{1'b0}}, 1'b1};
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  assign rconv  = bin2gray(ptr_t'(rbin_d));
  assign rptr_d = rconv[PW-1:0];

  // wbin_q adds one stage after the sync chain
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wbin_q  <= '0;
      rbin_q  <= '0;
      rptr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      rbin_q  <= rbin_d;
      rptr_q  <= rptr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign readpointer_o = rptr_q;
  assign data_o        = data_q;
  assign valid_o       = valid_q;
  assign fill_o        = wbin_q - rbin_q;

endmodule

// File: doc/dc_event_reader.md
DC_EVENT_READER -- requirements
Module: dc_event_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of one event/data word.
REQ-002 Parameter BUFFER_DEPTH, default 8: number of remote buffer slots; SHALL be a power of two, at least 2.
REQ-003 Parameter SYNC_STAGES, default 2: number of flops in the writetoken synchronizer, at least 2.
REQ-004 Derived AW = log2(BUFFER_DEPTH); pointer width is AW+1.
REQ-005 clk_i  in  1  reader-domain clock, the only clock.
REQ-006 rstn_i  in  1  asynchronous active-low reset.
REQ-007 data_async_i  in  BUFFER_DEPTH*DATA_WIDTH  remote writer's slot array; slot k is bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 writetoken_i  in  AW+1  remote write pointer, Gray-coded, asynchronous to clk_i.
REQ-009 readpointer_o  out  AW+1  local read pointer, Gray-coded, registered, returned to the writer.
REQ-010 data_o  out  DATA_WIDTH  output word, registered.
REQ-011 valid_o  out  1  data_o holds an unconsumed word.
REQ-012 ready_i  in  1  consumer accepts data_o.
REQ-013 fill_o  out  AW+1  slots pending in the remote buffer, excluding the output register.

Function
REQ-014 writetoken_i SHALL pass through a SYNC_STAGES flop chain before any use; no other logic SHALL see the raw value.
REQ-015 The synchronized write pointer SHALL be converted Gray->binary (wbin); the local read pointer is held in binary (rbin), and readpointer_o = gray(rbin), registered.
REQ-016 empty SHALL be wbin == rbin over all AW+1 bits; fill_o = wbin - rbin, modulo 2^(AW+1).
REQ-017 load = !empty && (!valid_o || ready_i).
REQ-018 On load: data_o <= slot rbin[AW-1:0], valid_o <= 1, rbin <= rbin+1 (wraps modulo 2^(AW+1)).
REQ-019 On valid_o && ready_i without load: valid_o <= 0; data_o holds its value.
REQ-020 valid_o && !ready_i: data_o, valid_o and rbin SHALL hold (output stable under backpressure).
REQ-021 Latency: a writetoken_i change sampled at edge N SHALL produce valid_o=1 after edge N+SYNC_STAGES+1 when the output register is free.
REQ-022 Throughput: one word per cycle with ready_i held at 1 and the buffer non-empty.
REQ-023 A slot SHALL be read only while the synchronized pointer shows it written; the pointer increment in the load cycle frees that slot for the writer.
REQ-024 fill_o > BUFFER_DEPTH cannot occur with a legal writer; no check is made and no behaviour is defined for it.
REQ-025 Simultaneous consume and load: the new word replaces data_o and valid_o stays 1 with no bubble.

Reset
REQ-026 rstn_i low SHALL asynchronously clear all synchronizer flops, rbin, readpointer_o, data_o, valid_o and fill_o to 0.
REQ-027 Reset mid-transfer discards the output register and pending slots; the remote writer SHALL be reset in the same reset window.
REQ-028 Deassertion of rstn_i is synchronized externally; the block does not resynchronize it.

Structure
REQ-029 The Gray<->binary conversion functions SHALL live in shared package dc_fifo_pkg, for reuse by the writer side.
REQ-030 The synchronizer SHALL be sub-module dc_sync_bus (width and stage parameters), kept separate so it can carry synthesis and CDC constraints.
REQ-031 No combinational path SHALL exist from writetoken_i or data_async_i to any output.

Verification (DATA_WIDTH=8, BUFFER_DEPTH=8, SYNC_STAGES=2)
REQ-032 Reset, then idle -> readpointer_o=0, valid_o=0, data_o=0x00, fill_o=0.
REQ-033 Slot0=0xA5, writetoken_i 0000->0001 at edge 0, ready_i=0 -> valid_o=1 and data_o=0xA5 after edge 3; readpointer_o=0001; fill_o=0; word held for 10 cycles.
REQ-034 Writer fills 8 slots (writetoken_i=gray(8)=1100), ready_i=0 -> one load occurs, then fill_o=7 and readpointer_o=0001, stable.
REQ-035 Stream 20 words 0x00..0x13 with ready_i=1 -> output order 0x00..0x13, no gaps once primed; final readpointer_o=gray(4)=0110.
REQ-036 ready_i toggling 1,0,1,0 during streaming -> no loss or duplication; data_o constant whenever valid_o=1 and ready_i=0.
REQ-037 rstn_i asserted with 3 words pending -> all outputs 0 in the same cycle, asynchronously; after release and a writer reset, the first new word arrives from slot 0.
